// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Turns a two-channel quadrature input (rotary encoder A/B) into
//   single-cycle step/dir strobes using the same en/up convention as the
//   up/down binary counter, and keeps an N-bit position register of its own.
//
//   Pipeline: 2-FF synchronizer -> per-channel persistence filter ->
//   x4 transition decoder -> position register (clear > load > step).
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   a, b        quadrature channels, asynchronous to clk
//   syn_clr     synchronous clear of pos and err_sticky
//   load        synchronous load of pos from d
//   d           load value (N bits)
//   step        one-cycle strobe per valid transition (counter en)
//   dir         direction of the last step, 1 = up (counter up)
//   err         one-cycle strobe when both channels changed together
//   err_sticky  set by err, cleared only by syn_clr or reset
//   pos         current position (N bits)
//   max_tick    high while pos is all ones
//   min_tick    high while pos is zero

module quad_step_decoder #(
    parameter int N    = 8,
    parameter int FILT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a,
    input  logic         b,
    input  logic         syn_clr,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic         step,
    output logic         dir,
    output logic         err,
    output logic         err_sticky,
    output logic [N-1:0] pos,
    output logic         max_tick,
    output logic         min_tick
);

    localparam int CW = $clog2(FILT + 1);

    // Channel pairs are packed as {a, b} throughout: bit 1 = A, bit 0 = B.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [1:0]    filt_nxt;
    logic [CW-1:0] cnt     [2];
    logic [CW-1:0] cnt_nxt [2];

    logic [1:0]    prev;
    logic          init;

    logic          changed;
    logic          both_changed;
    logic          move_up;
    logic          step_nxt;
    logic          err_nxt;
    logic [N-1:0]  pos_nxt;

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {a, b};
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Persistence filter: a channel change is accepted only after the
    // synchronized sample has disagreed with the filtered value for FILT
    // consecutive cycles. Any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_nxt[i] = filt[i];
            cnt_nxt[i]  = '0;
            if (sync2[i] != filt[i]) begin
                if (cnt[i] == CW'(FILT - 1)) begin
                    filt_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            filt <= filt_nxt;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoder. The decision is made on the filter's next value so that the
    // step strobe and the position update land on the same edge at which
    // the filter accepts the change.
    // ------------------------------------------------------------------
    always_comb begin
        changed      = (filt_nxt != prev);
        both_changed = &(filt_nxt ^ prev);

        // Up sequence 00 -> 10 -> 11 -> 01 -> 00; every other single-bit
        // change is a down move.
        case ({prev, filt_nxt})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move_up = 1'b1;
            default:                                move_up = 1'b0;
        endcase

        // The first accepted update after reset only aligns prev with the
        // real pin state.
        step_nxt = changed && !init && !both_changed;
        err_nxt  = changed && !init &&  both_changed;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 2'b00;
            init <= 1'b1;
            step <= 1'b0;
            err  <= 1'b0;
            dir  <= 1'b0;
        end else begin
            step <= step_nxt;
            err  <= err_nxt;
            if (changed) begin
                prev <= filt_nxt;
                init <= 1'b0;
            end
            if (step_nxt) begin
                dir <= move_up;
            end
        end
    end

    // ------------------------------------------------------------------
    // Position register: clear beats load beats step. A step that collides
    // with clear or load is lost from pos but still strobes step/dir.
    // ------------------------------------------------------------------
    always_comb begin
        pos_nxt = pos;
        if (syn_clr) begin
            pos_nxt = '0;
        end else if (load) begin
            pos_nxt = d;
        end else if (step_nxt) begin
            pos_nxt = move_up ? pos + 1'b1 : pos - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos        <= '0;
            err_sticky <= 1'b0;
        end else begin
            pos <= pos_nxt;
            // Setting wins over clearing so an error in the clear cycle
            // is not lost.
            if (err_nxt) begin
                err_sticky <= 1'b1;
            end else if (syn_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

    assign max_tick = &pos;
    assign min_tick = ~|pos;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed self-checking bench for quad_step_decoder (N=8, FILT=2).
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_quad_step_decoder;

    localparam int N    = 8;
    localparam int FILT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         a, b;
    logic         syn_clr, load;
    logic [N-1:0] d;
    logic         step, dir, err, err_sticky;
    logic [N-1:0] pos;
    logic         max_tick, min_tick;

    int tests  = 0;
    int failed = 0;

    // observation window counters
    int cyc;
    int step_seen;
    int err_seen;
    int first_step;
    logic last_dir;

    quad_step_decoder #(.N(N), .FILT(FILT)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .syn_clr(syn_clr), .load(load), .d(d),
        .step(step), .dir(dir), .err(err), .err_sticky(err_sticky),
        .pos(pos), .max_tick(max_tick), .min_tick(min_tick)
    );

    always #5 clk = ~clk;

    task automatic clear_watch();
        cyc = 0; step_seen = 0; err_seen = 0; first_step = 0; last_dir = 1'bx;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (step === 1'b1) begin
                step_seen++;
                last_dir = dir;
                if (first_step == 0) first_step = cyc;
            end
            if (err === 1'b1) err_seen++;
        end
    endtask

    task automatic test_reset();
        a = 1; b = 1; syn_clr = 0; load = 0; d = '0;
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        clear_watch();
        tick(10);
        tests++; if (step_seen !== 0) begin failed++; $display("FAIL reset_step got=%0d exp=0", step_seen); end
        tests++; if (err_seen !== 0) begin failed++; $display("FAIL reset_err got=%0d exp=0", err_seen); end
        tests++; if (pos !== 8'h00) begin failed++; $display("FAIL reset_pos got=%h exp=00", pos); end
        tests++; if (min_tick !== 1'b1) begin failed++; $display("FAIL reset_min_tick got=%b exp=1", min_tick); end
        tests++; if (max_tick !== 1'b0) begin failed++; $display("FAIL reset_max_tick got=%b exp=0", max_tick); end
        tests++; if (err_sticky !== 1'b0) begin failed++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
        tests++; if (dir !== 1'b0) begin failed++; $display("FAIL reset_dir got=%b exp=0", dir); end
    endtask

    task automatic test_up_sequence();
        logic [1:0] seq [4];
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        // From 11 two up moves (01, 00) reach 00 with pos = 2.
        {a, b} = 2'b01; tick(10);
        {a, b} = 2'b00; tick(10);
        tests++; if (pos !== 8'h02) begin failed++; $display("FAIL prep_pos got=%h exp=02", pos); end
        syn_clr = 1; tick(1); syn_clr = 0;
        tests++; if (pos !== 8'h00) begin failed++; $display("FAIL prep_clr_pos got=%h exp=00", pos); end
        for (int i = 0; i < 4; i++) begin
            clear_watch();
            {a, b} = seq[i];
            tick(10);
            tests++; if (step_seen !== 1) begin failed++; $display("FAIL up%0d_steps got=%0d exp=1", i, step_seen); end
            tests++; if (last_dir !== 1'b1) begin failed++; $display("FAIL up%0d_dir got=%b exp=1", i, last_dir); end
            tests++; if (first_step !== FILT + 2) begin failed++; $display("FAIL up%0d_latency got=%0d exp=%0d", i, first_step, FILT + 2); end
        end
        tests++; if (pos !== 8'h04) begin failed++; $display("FAIL up_pos got=%h exp=04", pos); end
    endtask

    task automatic test_wrap();
        d = 8'hFF; load = 1; tick(1); load = 0;
        tests++; if (pos !== 8'hFF) begin failed++; $display("FAIL load_ff got=%h exp=ff", pos); end
        tests++; if (max_tick !== 1'b1) begin failed++; $display("FAIL load_ff_max got=%b exp=1", max_tick); end
        {a, b} = 2'b10; tick(10);
        tests++; if (pos !== 8'h00) begin failed++; $display("FAIL wrap_up_pos got=%h exp=00", pos); end
        tests++; if (min_tick !== 1'b1) begin failed++; $display("FAIL wrap_up_min got=%b exp=1", min_tick); end
        clear_watch();
        {a, b} = 2'b00; tick(10);
        tests++; if (pos !== 8'hFF) begin failed++; $display("FAIL wrap_dn_pos got=%h exp=ff", pos); end
        tests++; if (max_tick !== 1'b1) begin failed++; $display("FAIL wrap_dn_max got=%b exp=1", max_tick); end
        tests++; if (dir !== 1'b0) begin failed++; $display("FAIL wrap_dn_dir got=%b exp=0", dir); end
    endtask

    task automatic test_glitch();
        clear_watch();
        a = 1; tick(1); a = 0; tick(10);
        tests++; if (step_seen !== 0) begin failed++; $display("FAIL glitch1_steps got=%0d exp=0", step_seen); end
        tests++; if (pos !== 8'hFF) begin failed++; $display("FAIL glitch1_pos got=%h exp=ff", pos); end
        clear_watch();
        a = 1; tick(2); a = 0; tick(10);
        tests++; if (step_seen !== 2) begin failed++; $display("FAIL glitch2_steps got=%0d exp=2", step_seen); end
        tests++; if (pos !== 8'hFF) begin failed++; $display("FAIL glitch2_pos got=%h exp=ff", pos); end
        tests++; if (dir !== 1'b0) begin failed++; $display("FAIL glitch2_dir got=%b exp=0", dir); end
    endtask

    task automatic test_error();
        clear_watch();
        {a, b} = 2'b11; tick(10);
        tests++; if (err_seen !== 1) begin failed++; $display("FAIL err_pulses got=%0d exp=1", err_seen); end
        tests++; if (step_seen !== 0) begin failed++; $display("FAIL err_steps got=%0d exp=0", step_seen); end
        tests++; if (err_sticky !== 1'b1) begin failed++; $display("FAIL err_sticky got=%b exp=1", err_sticky); end
        tests++; if (pos !== 8'hFF) begin failed++; $display("FAIL err_pos got=%h exp=ff", pos); end
        clear_watch();
        {a, b} = 2'b01; tick(10);
        tests++; if (step_seen !== 1) begin failed++; $display("FAIL post_err_steps got=%0d exp=1", step_seen); end
        tests++; if (pos !== 8'h00) begin failed++; $display("FAIL post_err_pos got=%h exp=00", pos); end
        {a, b} = 2'b00; tick(10);
        syn_clr = 1; tick(1); syn_clr = 0;
        tests++; if (pos !== 8'h00) begin failed++; $display("FAIL clr_pos got=%h exp=00", pos); end
        tests++; if (err_sticky !== 1'b0) begin failed++; $display("FAIL clr_sticky got=%b exp=0", err_sticky); end
    endtask

    task automatic test_clr_load_collision();
        // pins 00 -> 10 (up) with clear and load both present in the step cycle
        d = 8'h55;
        clear_watch();
        {a, b} = 2'b10; tick(FILT + 1);
        syn_clr = 1; load = 1; tick(1); syn_clr = 0; load = 0;
        tests++; if (first_step !== FILT + 2) begin failed++; $display("FAIL clrld_step got=%0d exp=%0d", first_step, FILT + 2); end
        tests++; if (pos !== 8'h00) begin failed++; $display("FAIL clrld_pos got=%h exp=00", pos); end
        tick(6);
        // 10 -> 11 (up) with load alone in the step cycle
        clear_watch();
        {a, b} = 2'b11; tick(FILT + 1);
        load = 1; tick(1); load = 0;
        tests++; if (first_step !== FILT + 2) begin failed++; $display("FAIL ld_step got=%0d exp=%0d", first_step, FILT + 2); end
        tests++; if (pos !== 8'h55) begin failed++; $display("FAIL ld_pos got=%h exp=55", pos); end
        tick(6);
        tests++; if (pos !== 8'h55) begin failed++; $display("FAIL ld_hold_pos got=%h exp=55", pos); end
        // 11 -> 00 is illegal; syn_clr in the same cycle must not clear the sticky flag
        clear_watch();
        {a, b} = 2'b00; tick(FILT + 1);
        syn_clr = 1; tick(1); syn_clr = 0;
        tests++; if (err_seen !== 1) begin failed++; $display("FAIL errclr_pulse got=%0d exp=1", err_seen); end
        tests++; if (err_sticky !== 1'b1) begin failed++; $display("FAIL errclr_sticky got=%b exp=1", err_sticky); end
        tests++; if (pos !== 8'h00) begin failed++; $display("FAIL errclr_pos got=%h exp=00", pos); end
        tick(6);
    endtask

    task automatic test_midop_reset();
        d = 8'h33; load = 1; tick(1); load = 0;
        {a, b} = 2'b01; tick(2);
        reset = 1;
        #1;
        tests++; if (pos !== 8'h00) begin failed++; $display("FAIL async_pos got=%h exp=00", pos); end
        tests++; if (err_sticky !== 1'b0) begin failed++; $display("FAIL async_sticky got=%b exp=0", err_sticky); end
        repeat (2) @(negedge clk);
        reset = 0;
        clear_watch();
        tick(10);
        tests++; if (step_seen !== 0 || err_seen !== 0) begin failed++; $display("FAIL reinit got steps=%0d errs=%0d exp 0/0", step_seen, err_seen); end
        // 01 -> 00 is up
        clear_watch();
        {a, b} = 2'b00; tick(10);
        tests++; if (step_seen !== 1 || last_dir !== 1'b1) begin failed++; $display("FAIL reinit_step got steps=%0d dir=%b exp 1/1", step_seen, last_dir); end
        tests++; if (pos !== 8'h01) begin failed++; $display("FAIL reinit_pos got=%h exp=01", pos); end
    endtask

    initial begin
        test_reset();
        test_up_sequence();
        test_wrap();
        test_glitch();
        test_error();
        test_clr_load_collision();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Converts a 2-channel quadrature input (A/B, e.g. rotary encoder) into single-cycle step/dir strobes.
- The strobes use the same en/up convention as the team's up/down binary counter.
- An integrated N-bit position register has synchronous clear, parallel load and max/min ticks.
- Sits between the board encoder pins and any position or counter logic. It is the input side that generates the count events the counter consumes.

Parameters:
N, 8, width of position register pos and load value d.
FILT, 2, number of consecutive identical synchronized samples required before a channel change is accepted (legal values 1..15).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
a  input  1  quadrature channel A, asynchronous to clk.
b  input  1  quadrature channel B, asynchronous to clk.
syn_clr  input  1  synchronous clear of pos and err_sticky.
load  input  1  synchronous load of pos from d.
d  input  N  load value.
step  output  1  one-cycle strobe per valid quadrature transition (counter en).
dir  output  1  direction of last step: 1 = up, 0 = down (counter up).
err  output  1  one-cycle strobe on an illegal transition (both channels changed).
err_sticky  output  1  set by err, held until syn_clr or reset.
pos  output  N  current position.
max_tick  output  1  high while pos == all ones.
min_tick  output  1  high while pos == 0.

Behaviour:
- Reset (async, active-high): synchronizers, filters and previous-state register go to 00. Also on reset: pos=0, step=0, dir=0, err=0, err_sticky=0, init flag set.
- Synchronizer: each channel passes through 2 flip-flops. Raw pins are never used elsewhere.
- Filter, per channel: holds filtered value f and a counter cnt of width ceil(log2(FILT+1)).
  - If the synchronized sample s equals f: cnt <= 0.
  - If s differs from f and cnt == FILT-1: f <= s, cnt <= 0.
  - If s differs from f otherwise: cnt <= cnt+1.
  - With FILT=1, f follows s with one cycle of delay.
  - A pulse shorter than FILT cycles at the synchronizer output is discarded.
- Decoder: compares the new filtered pair {fa,fb} with the registered previous pair.
  - Up sequence: 00→10→11→01→00. Down sequence is the reverse. Every legal edge counts (x4 decoding).
  - Legal change: step=1 for exactly one cycle. dir = direction, registered and held until the next step.
  - Both bits change in the same update: err=1 for one cycle, err_sticky=1, no step, pos unchanged. The previous pair is still updated to the new value.
  - No change: step=0, err=0.
- Init: the first filtered update after reset, from the reset value 00 to the actual pin state, only loads the previous pair and clears the init flag. It produces no step and no err.
- Latency: a pin change stable from edge k appears at the synchronizer output after edge k+1. step and the pos update occur at edge k+FILT+1, so step is high in the following cycle. A new step is possible every FILT cycles at most.
- Position register priority (synchronous): syn_clr > load > step.
  - syn_clr: pos=0, err_sticky=0.
  - load: pos=d, err_sticky unchanged.
  - step: pos = pos+1 if dir up, else pos-1, modulo 2^N (wraps silently).
  - A step coinciding with syn_clr or load is dropped from pos, but step and dir still pulse.
  - An err coinciding with syn_clr leaves err_sticky=1, because the set wins.
- max_tick and min_tick are combinational from the pos register. They are not pulses; they stay high as long as the condition holds.
- Reset asserted mid-operation: all state returns to its reset values immediately and the init rule applies again.

Test Plan:
- Reset with a=1, b=1, FILT=2: after release no step and no err; pos=0, min_tick=1, err_sticky=0.
- From 00, drive the up sequence 10,11,01,00, each held 10 cycles: four step pulses with dir=1 and pos=4. Each step is 4 cycles after the pin edge (FILT+2).
- pos loaded with 8'hFF, one up edge: pos=8'h00 and min_tick=1. Then one down edge: pos=8'hFF, max_tick=1, dir=0.
- Glitch rejection, FILT=2: a pulses high for 1 cycle after sync: no step, pos unchanged. A 2-cycle pulse gives one up step then one down step, returning pos to its prior value.
- Pins change 00→11 simultaneously: err pulses once, err_sticky=1, pos unchanged. A subsequent legal edge steps normally. syn_clr clears pos and err_sticky.
- syn_clr and load asserted on the step cycle (d=8'h55): pos=0, step still pulses. Then load alone with a step: pos=8'h55.
